// File: rtl/register_file_pkg.sv
// Shared sizing constants for the general-purpose register file.
package register_file_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 0;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Two-read, one-write register file; register 0 is hard-wired to zero.
// Reads are combinational and reset clears every register on a clock edge.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] readReg1,
   input  logic [ADDR_WIDTH-1:0] readReg2,
   input  logic [ADDR_WIDTH-1:0] writeReg,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  regWrite,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2
);

   localparam int Depth = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

   logic [DATA_WIDTH-1:0] regFile_r [Depth];
   logic [DATA_WIDTH-1:0] readData1_s;
   logic [DATA_WIDTH-1:0] readData2_s;
   logic                  writeEn_s;

   // Address 0 is never stored, so writes there are dropped here.
   assign writeEn_s = regWrite && (writeReg != ZeroAddr);

   // Storage update: synchronous reset wins over any write in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            regFile_r[i] <= '0;
         end
      end else if (writeEn_s) begin
         regFile_r[writeReg] <= writeData;
      end else begin
         regFile_r[writeReg] <= regFile_r[writeReg];
      end
   end

   // Read port 1 mux, no bypass from the write port.
   always_comb begin
      readData1_s = '0;
      if (readReg1 == ZeroAddr) begin
         readData1_s = '0;
      end else begin
         readData1_s = regFile_r[readReg1];
      end
   end

   // Read port 2 mux, independent of port 1.
   always_comb begin
      readData2_s = '0;
      if (readReg2 == ZeroAddr) begin
         readData2_s = '0;
      end else begin
         readData2_s = regFile_r[readReg2];
      end
   end

   assign readData1 = readData1_s;
   assign readData2 = readData2_s;

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
module tb_register_file;

   logic        clk;
   logic [4:0]  readReg1;
   logic [4:0]  readReg2;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        regWrite;
   logic        rst_n;
   logic [31:0] readData1;
   logic [31:0] readData2;

   int checkCount;
   int errorCount;

   register_file dut (
      .clk       (clk),
      .readReg1  (readReg1),
      .readReg2  (readReg2),
      .writeReg  (writeReg),
      .writeData (writeData),
      .regWrite  (regWrite),
      .rst_n     (rst_n),
      .readData1 (readData1),
      .readData2 (readData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeOne(input logic [4:0] addr, input logic [31:0] data);
      writeReg  = addr;
      writeData = data;
      regWrite  = 1'b1;
      tick();
      regWrite  = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      readReg1   = 5'd0;
      readReg2   = 5'd0;
      writeReg   = 5'd0;
      writeData  = 32'h0;
      regWrite   = 1'b0;
      rst_n      = 1'b0;

      // Reset for two edges, then probe two arbitrary registers
      tick();
      tick();
      readReg1 = 5'd5;
      readReg2 = 5'd31;
      #1;
      checkVal("reset_r5",  readData1, 32'h0000_0000);
      checkVal("reset_r31", readData2, 32'h0000_0000);
      rst_n = 1'b1;

      // Successive writes
      writeOne(5'd10, 32'hFFFF_FFFF);
      writeOne(5'd20, 32'hFFFF_FFFE);
      writeOne(5'd30, 32'hFFFF_FFFD);
      readReg1 = 5'd20;
      readReg2 = 5'd30;
      #1;
      checkVal("wr_r20", readData1, 32'hFFFF_FFFE);
      checkVal("wr_r30", readData2, 32'hFFFF_FFFD);
      readReg1 = 5'd10;
      readReg2 = 5'd10;
      #1;
      checkVal("wr_r10_p1", readData1, 32'hFFFF_FFFF);
      checkVal("wr_r10_p2", readData2, 32'hFFFF_FFFF);

      // Register 0 ignores writes
      writeOne(5'd0, 32'h1234_5678);
      readReg1 = 5'd0;
      readReg2 = 5'd0;
      #1;
      checkVal("zero_p1", readData1, 32'h0000_0000);
      checkVal("zero_p2", readData2, 32'h0000_0000);

      // Write enable low leaves storage untouched
      writeReg  = 5'd10;
      writeData = 32'hAAAA_AAAA;
      regWrite  = 1'b0;
      tick();
      readReg1 = 5'd10;
      #1;
      checkVal("noen_r10", readData1, 32'hFFFF_FFFF);

      // Read-during-write: old value before the edge, new value after
      readReg1  = 5'd20;
      readReg2  = 5'd30;
      writeReg  = 5'd20;
      writeData = 32'h5555_5555;
      regWrite  = 1'b1;
      #1;
      checkVal("rdw_before", readData1, 32'hFFFF_FFFE);
      tick();
      regWrite = 1'b0;
      checkVal("rdw_after",  readData1, 32'h5555_5555);
      checkVal("rdw_other",  readData2, 32'hFFFF_FFFD);

      // Preload reg 7, then check reset has no asynchronous effect
      writeOne(5'd7, 32'hDEAD_BEEF);
      readReg1 = 5'd7;
      rst_n    = 1'b0;
      #1;
      checkVal("rst_not_async", readData1, 32'hDEAD_BEEF);

      // Reset edge coincident with a write to reg 7
      writeReg  = 5'd7;
      writeData = 32'h0000_0001;
      regWrite  = 1'b1;
      tick();
      regWrite = 1'b0;
      checkVal("rstpri_r7", readData1, 32'h0000_0000);
      for (int i = 1; i < 32; i += 10) begin
         readReg2 = 5'(i);
         #1;
         checkVal("rstpri_all", readData2, 32'h0000_0000);
      end
      readReg2 = 5'd10;
      #1;
      checkVal("rstpri_r10", readData2, 32'h0000_0000);
      rst_n = 1'b1;

      // Write after reset release still works
      writeOne(5'd31, 32'h0F0F_0F0F);
      readReg2 = 5'd31;
      #1;
      checkVal("post_rst_r31", readData2, 32'h0F0F_0F0F);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; depth is 2**ADDR_WIDTH (32).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-005 Port readReg1, input, ADDR_WIDTH bits, SHALL be the read address for port 1.
REQ-006 Port readReg2, input, ADDR_WIDTH bits, SHALL be the read address for port 2.
REQ-007 Port writeReg, input, ADDR_WIDTH bits, SHALL be the write address.
REQ-008 Port writeData, input, DATA_WIDTH bits, SHALL be the write data.
REQ-009 Port regWrite, input, 1 bit, SHALL be the write enable, active-high.
REQ-010 Port readData1, output, DATA_WIDTH bits, SHALL carry the contents of register readReg1.
REQ-011 Port readData2, output, DATA_WIDTH bits, SHALL carry the contents of register readReg2.
REQ-012 Declaration order SHALL be clk, readReg1, readReg2, writeReg, writeData, regWrite, rst_n, readData1, readData2, so that positional instantiation binds correctly.

Function
REQ-013 The block SHALL hold 32 registers of DATA_WIDTH bits each.
REQ-014 On a rising clk edge with rst_n=1 and regWrite=1, writeData SHALL be stored into register writeReg.
REQ-015 With regWrite=0, no register SHALL change.
REQ-016 Register 0 SHALL read as zero at all times; writes to address 0 SHALL be ignored.
REQ-017 Both read ports SHALL be combinational, with zero-cycle latency from address or state change to output.
REQ-018 The two read ports SHALL be independent and may address the same register simultaneously.
REQ-019 Read-during-write to the same address SHALL return the pre-edge value until the edge; the new value SHALL appear immediately after the edge, with no write-to-read bypass.
REQ-020 X or unknown addresses need not be handled; with valid addresses the outputs SHALL never be X after reset.
REQ-021 The block SHALL use no handshake, no state machine, and no arithmetic.

Reset
REQ-022 On a rising clk edge with rst_n=0, all registers SHALL clear to 0.
REQ-023 Reset SHALL take priority over a simultaneous write.
REQ-024 While rst_n=0, readData1 and readData2 SHALL read 0 after the first reset edge.
REQ-025 rst_n SHALL have no asynchronous effect; reset asserted mid-operation SHALL take effect only at the next rising edge.

Structure
REQ-026 A shared package SHALL define DATA_WIDTH=32, ADDR_WIDTH=5, NUM_REGS=32 and ZERO_REG=0.
REQ-027 The design SHALL be a single flat module containing the storage array, the write process and two read multiplexers; no sub-module is required.

Verification
REQ-028 Reset: rst_n=0 for 2 edges, then read addresses 5 and 31 -> both outputs 0x00000000.
REQ-029 Writes and reads: with regWrite=1, write 0xFFFFFFFF to reg 10, 0xFFFFFFFE to reg 20 and 0xFFFFFFFD to reg 30 on successive edges; read 20 and 30 -> 0xFFFFFFFE and 0xFFFFFFFD, and read 10 -> 0xFFFFFFFF.
REQ-030 Zero register: write 0x12345678 to reg 0 -> reading reg 0 on both ports returns 0x00000000.
REQ-031 Write enable: with regWrite=0, drive 0xAAAAAAAA to reg 10 -> reg 10 still reads 0xFFFFFFFF.
REQ-032 Read-during-write: reg 20=0xFFFFFFFE, write 0x55555555 to reg 20 while reading it -> 0xFFFFFFFE before the edge and 0x55555555 after it.
REQ-033 Reset priority: assert rst_n=0 together with a write of 0x1 to reg 7 -> reg 7 and all other registers read 0 after the edge.
